// File: rtl/qpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qpoint_pkg
// Purpose  : Shared constants and state encoding for the qpoint datapath blocks.
// Revision : 1.0 - initial release
// ============================================================================
package qpoint_pkg;

    localparam int QP_Q = 23;
    localparam int QP_N = 32;

    localparam logic [QP_N-2:0] MAG_MAX = {(QP_N-1){1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } qacc_state_t;

endpackage : qpoint_pkg
`default_nettype wire

// File: rtl/qacc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : qacc_seq_if
// Purpose  : Control/data handshake bundle between a term producer and qacc_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface qacc_seq_if
    import qpoint_pkg::*;
#(
    parameter int N     = QP_N,
    parameter int LEN_W = 8
);
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    logic [N-1:0]     i_data;
    logic             o_ready;
    logic [N-1:0]     o_sum;
    logic             o_complete;
    logic             o_overflow;
    logic             o_busy;

    modport master (
        output i_start, i_len, i_valid, i_data,
        input  o_ready, o_sum, o_complete, o_overflow, o_busy
    );

    modport slave (
        input  i_start, i_len, i_valid, i_data,
        output o_ready, o_sum, o_complete, o_overflow, o_busy
    );
endinterface : qacc_seq_if
`default_nettype wire

// File: rtl/qadd_sat.sv
`default_nettype none
// ============================================================================
// Module   : qadd_sat
// Purpose  : Combinational saturating sign-magnitude Q-format adder.
// Revision : 1.0 - initial release
// ============================================================================
module qadd_sat
    import qpoint_pkg::*;
#(
    parameter int Q = QP_Q,
    parameter int N = QP_N
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    output logic      [N-1:0] sum,
    output logic              ovf
);
    localparam int MW = N - 1;

    if (Q >= MW) begin : g_q_range_err
        $error("qadd_sat: Q must be smaller than N-1");
    end

    logic [MW-1:0] w_mag_a;
    logic [MW-1:0] w_mag_b;
    logic [MW-1:0] w_mag_r;
    logic [MW:0]   w_add;
    logic          w_sa;
    logic          w_sb;
    logic          w_sr;

    always_comb begin
        w_mag_a = a[MW-1:0];
        w_mag_b = b[MW-1:0];
        // A zero magnitude is always positive, so -0 behaves as +0.
        w_sa    = a[N-1] & (|w_mag_a);
        w_sb    = b[N-1] & (|w_mag_b);
        w_add   = {1'b0, w_mag_a} + {1'b0, w_mag_b};
        w_mag_r = '0;
        w_sr    = 1'b0;
        ovf     = 1'b0;
        if (w_sa == w_sb) begin
            w_sr = w_sa;
            if (w_add[MW]) begin
                w_mag_r = '1;
                ovf     = 1'b1;
            end else begin
                w_mag_r = w_add[MW-1:0];
            end
        end else if (w_mag_a >= w_mag_b) begin
            w_mag_r = w_mag_a - w_mag_b;
            w_sr    = w_sa;
        end else begin
            w_mag_r = w_mag_b - w_mag_a;
            w_sr    = w_sb;
        end
    end

    assign sum = {w_sr & (|w_mag_r), w_mag_r};

endmodule : qadd_sat
`default_nettype wire

// File: rtl/qacc_seq.sv
`default_nettype none
// ============================================================================
// Module   : qacc_seq
// Purpose  : Sequential saturating accumulator of a programmed number of Q terms.
// Revision : 1.0 - initial release
// ============================================================================
module qacc_seq
    import qpoint_pkg::*;
#(
    parameter int Q     = QP_Q,
    parameter int N     = QP_N,
    parameter int LEN_W = 8
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst,
    qacc_seq_if.slave  bus
);
    qacc_state_t      r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [N-1:0]     r_sum;
    logic             r_ovf;
    logic             r_ready;
    logic             r_complete;
    logic             r_busy;

    logic [N-1:0]     w_sum;
    logic             w_ovf;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_accept;

    qadd_sat #(
        .Q (Q),
        .N (N)
    ) u_qadd_sat (
        .a   (r_sum),
        .b   (bus.i_data),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    assign w_count_nxt = r_count + 1'b1;
    // r_ready is only ever set while in ACC, so it alone qualifies an accept.
    assign w_accept    = bus.i_valid & r_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b0;
            r_complete <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_len   <= bus.i_len;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        if (bus.i_len == '0) begin
                            r_state    <= ST_DONE;
                            r_complete <= 1'b1;
                        end else begin
                            r_state <= ST_ACC;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_sum   <= w_sum;
                        r_ovf   <= r_ovf | w_ovf;
                        r_count <= w_count_nxt;
                        if (w_count_nxt == r_len) begin
                            r_state    <= ST_DONE;
                            r_ready    <= 1'b0;
                            r_complete <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_complete <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ready    <= 1'b0;
                    r_complete <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = r_ready;
    assign bus.o_sum      = r_sum;
    assign bus.o_complete = r_complete;
    assign bus.o_overflow = r_ovf;
    assign bus.o_busy     = r_busy;

endmodule : qacc_seq
`default_nettype wire

// File: tb/tb_qacc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_qacc_seq
// Purpose  : Directed self-checking bench for qacc_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qacc_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    qacc_seq_if #(.N(32), .LEN_W(8)) bus ();

    qacc_seq #(
        .Q     (23),
        .N     (32),
        .LEN_W (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_acc(input logic [7:0] len);
        bus.i_start = 1'b1;
        bus.i_len   = len;
        cyc();
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (bus.o_sum !== 32'h0) begin
            n_fail++; $display("FAIL reset_sum: got %h expected %h", bus.o_sum, 32'h0);
        end
        n_checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_complete !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ovf=%b cmp=%b expected 0 0", bus.o_overflow, bus.o_complete);
        end
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs: got rdy=%b busy=%b expected 0 0", bus.o_ready, bus.o_busy);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [31:0] terms [3];
        terms[0] = 32'h00C00000;
        terms[1] = 32'h01000000;
        terms[2] = 32'h80400000;
        start_acc(8'd3);
        n_checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_enter_acc: got rdy=%b busy=%b expected 1 1", bus.o_ready, bus.o_busy);
        end
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = terms[i];
            cyc();
            if (i == 0) begin
                n_checks++;
                if (bus.o_sum !== 32'h00C00000) begin
                    n_fail++; $display("FAIL basic_partial: got %h expected %h", bus.o_sum, 32'h00C00000);
                end
            end
            if (i < 2) begin
                n_checks++;
                if (bus.o_complete !== 1'b0) begin
                    n_fail++; $display("FAIL basic_early_complete: got %b expected 0 (term %0d)", bus.o_complete, i);
                end
            end
        end
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h01800000) begin
            n_fail++; $display("FAIL basic_sum: got %h expected %h", bus.o_sum, 32'h01800000);
        end
        n_checks++;
        if (bus.o_complete !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got cmp=%b rdy=%b ovf=%b expected 1 0 0", bus.o_complete, bus.o_ready, bus.o_overflow);
        end
        cyc();
        n_checks++;
        if (bus.o_complete !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_sum !== 32'h01800000) begin
            n_fail++; $display("FAIL basic_idle_hold: got cmp=%b busy=%b sum=%h expected 0 0 01800000", bus.o_complete, bus.o_busy, bus.o_sum);
        end
    endtask

    task automatic test_cancel();
        start_acc(8'd2);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h00C00000;
        cyc();
        bus.i_data  = 32'h80C00000;
        cyc();
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h00000000 || bus.o_complete !== 1'b1) begin
            n_fail++; $display("FAIL cancel_zero: got sum=%h cmp=%b expected 00000000 1", bus.o_sum, bus.o_complete);
        end
        cyc();
    endtask

    task automatic test_saturation();
        start_acc(8'd3);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h64000000;
        cyc();
        n_checks++;
        if (bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_first_ovf: got %b expected 0", bus.o_overflow);
        end
        bus.i_data = 32'h32000000;
        cyc();
        n_checks++;
        if (bus.o_sum !== 32'h7FFFFFFF || bus.o_overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_clip: got sum=%h ovf=%b expected 7fffffff 1", bus.o_sum, bus.o_overflow);
        end
        bus.i_data = 32'h99000000;
        cyc();
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h66FFFFFF || bus.o_overflow !== 1'b1 || bus.o_complete !== 1'b1) begin
            n_fail++; $display("FAIL sat_final: got sum=%h ovf=%b cmp=%b expected 66ffffff 1 1", bus.o_sum, bus.o_overflow, bus.o_complete);
        end
        cyc();
        n_checks++;
        if (bus.o_overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_sticky_idle: got %b expected 1", bus.o_overflow);
        end
    endtask

    task automatic test_zero_len();
        start_acc(8'd0);
        n_checks++;
        if (bus.o_complete !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_sum !== 32'h0) begin
            n_fail++; $display("FAIL zero_len_done: got cmp=%b rdy=%b sum=%h expected 1 0 00000000", bus.o_complete, bus.o_ready, bus.o_sum);
        end
        n_checks++;
        if (bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL zero_len_ovf_clear: got %b expected 0", bus.o_overflow);
        end
        cyc();
        n_checks++;
        if (bus.o_complete !== 1'b0 || bus.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL zero_len_after: got cmp=%b rdy=%b expected 0 0", bus.o_complete, bus.o_ready);
        end
    endtask

    task automatic test_gaps();
        logic [3:0]  vpat;
        logic [31:0] dpat [4];
        int          accepts;
        vpat    = 4'b1001;
        dpat[0] = 32'h00800000;
        dpat[1] = 32'h7F000000;
        dpat[2] = 32'h7F000000;
        dpat[3] = 32'h81000000;
        accepts = 0;
        start_acc(8'd2);
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = vpat[3-i];
            bus.i_data  = dpat[i];
            bus.i_start = (i == 1);
            bus.i_len   = 8'd5;
            if (bus.i_valid && bus.o_ready) accepts++;
            cyc();
            if (i == 2) begin
                n_checks++;
                if (bus.o_complete !== 1'b0 || bus.o_ready !== 1'b1) begin
                    n_fail++; $display("FAIL gaps_mid: got cmp=%b rdy=%b expected 0 1", bus.o_complete, bus.o_ready);
                end
            end
        end
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        n_checks++;
        if (accepts !== 2) begin
            n_fail++; $display("FAIL gaps_accepts: got %0d expected 2", accepts);
        end
        n_checks++;
        if (bus.o_sum !== 32'h80800000 || bus.o_complete !== 1'b1) begin
            n_fail++; $display("FAIL gaps_sum: got sum=%h cmp=%b expected 80800000 1", bus.o_sum, bus.o_complete);
        end
        cyc();
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h00800000;
        cyc();
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h80800000 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL gaps_idle_valid: got sum=%h busy=%b expected 80800000 0", bus.o_sum, bus.o_busy);
        end
    endtask

    task automatic test_reset_mid();
        start_acc(8'd4);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h00800000;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h0 || bus.o_overflow !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_sum: got sum=%h ovf=%b expected 00000000 0", bus.o_sum, bus.o_overflow);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_complete !== 1'b0 || bus.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: got busy=%b cmp=%b rdy=%b expected 0 0 0", bus.o_busy, bus.o_complete, bus.o_ready);
        end
        cyc();
        n_checks++;
        if (bus.o_complete !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_complete: got %b expected 0", bus.o_complete);
        end
        start_acc(8'd1);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h80400000;
        cyc();
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_sum !== 32'h80400000 || bus.o_complete !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_restart: got sum=%h cmp=%b expected 80400000 1", bus.o_sum, bus.o_complete);
        end
        cyc();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len   = 8'd0;
        bus.i_valid = 1'b0;
        bus.i_data  = 32'h0;
        test_reset();
        test_basic();
        test_cancel();
        test_saturation();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qacc_seq
`default_nettype wire

// File: doc/qacc_seq.md
Name: qacc_seq

Overview:
- Sequential sign-magnitude Q-format accumulator. Sits directly downstream of qmult.
- Sums a programmed number of qmult products, one per handshake, into an N-bit sign-magnitude Q result.
- Saturates at full scale and reports a sticky overflow flag.
- Serves as the accumulate half of a dot-product/MAC datapath built from the qpoint blocks.

Parameters:
- Q, 23, fractional bits (matches qmult Q)
- N, 32, total width: bit N-1 is sign, N-2:0 is magnitude
- LEN_W, 8, width of the term-count field

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  begin a new accumulation; sampled only in IDLE
- i_len  in  LEN_W  number of terms to accumulate, latched with i_start
- i_valid  in  1  i_data holds a valid product
- i_data  in  N  sign-magnitude Q product from qmult
- o_ready  out  1  term accepted on an edge where i_valid && o_ready
- o_sum  out  N  running/final sum, sign-magnitude Q
- o_complete  out  1  one-cycle pulse when the sum is final
- o_overflow  out  1  sticky saturation flag for the current accumulation
- o_busy  out  1  high in ACC and DONE

Behaviour:
- Reset (i_rst=1 at an edge, including mid-operation): state IDLE, o_sum=0, o_overflow=0, o_complete=0, o_ready=0, o_busy=0, count=0.
- States and transitions:
  - IDLE: on i_start, latch i_len, clear o_sum, o_overflow and count. Go to DONE if i_len==0, otherwise to ACC.
  - ACC: o_ready=1. On each accept, o_sum <= sat_add(o_sum, i_data) and count++. The accept that makes count==len moves to DONE in the same edge.
  - DONE: o_complete=1 and o_ready=0 for exactly one cycle, then IDLE.
- o_sum updates at every accept edge, so partial sums are visible during ACC. o_sum and o_overflow hold after DONE until the next i_start or reset.
- i_start outside IDLE is ignored. i_valid outside ACC is ignored; no data is consumed.
- Latency: o_complete is asserted in the cycle after the edge that accepts the final term. With continuous i_valid, len terms take len cycles in ACC.
- sat_add(a,b), sign-magnitude, magnitudes of N-1 bits:
  - Equal signs: magnitude sum computed at N bits. A carry-out saturates the magnitude to all ones and sets o_overflow. The result keeps the common sign.
  - Different signs: the smaller magnitude is subtracted from the larger, and the result takes the sign of the larger.
  - Equal magnitudes give +0.
- Negative zero: -0 on input is treated as +0, and -0 is never produced; a zero magnitude forces the sign bit to 0.
- o_overflow is sticky. Subsequent terms still add normally from the saturated value.

Decomposition:
- Shared package qpoint_pkg holds:
  - state encoding constants ST_IDLE/ST_ACC/ST_DONE
  - default Q/N constants shared with qmult
  - MAG_MAX constant (N-1 ones)
- One combinational sub-module, qadd_sat, implements sat_add.
  - Ports: a, b, sum, ovf; parameterised Q and N.
  - Reusable by the other qpoint adders.

Test Plan:
- Basic sum: len=3 with terms 0x00C00000 (+1.5), 0x01000000 (+2.0), 0x80400000 (-0.5), i_valid continuous.
  - o_sum=0x01800000 (+3.0).
  - o_complete high exactly one cycle after the third accept; o_overflow=0.
- Cancellation: len=2 with terms 0x00C00000, 0x80C00000.
  - o_sum=0x00000000, never 0x80000000.
- Saturation: len=3 with terms 0x64000000 (+200), 0x32000000 (+100), 0x99000000 (-50).
  - After the 2nd accept: o_sum=0x7FFFFFFF and o_overflow=1.
  - Final: o_sum=0x66FFFFFF and o_overflow still 1.
- Zero length: i_start with i_len=0.
  - No o_ready at any point.
  - o_complete the next cycle with o_sum=0.
- Gaps and stray start: len=2, i_valid toggled 1,0,0,1, with i_start pulsed during ACC.
  - Exactly two accepts.
  - The stray i_start has no effect; sum is correct.
- Reset mid-operation: i_rst asserted after 1 of 4 terms.
  - Next cycle: IDLE, o_sum=0, o_overflow=0, o_busy=0, o_complete stays 0.
  - A new accumulation then completes correctly.
